muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 101 ++++++++++
 tb/tb_muldiv_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, 32 RUN cycles per op; `MULDIV_FASTPATH_EN enables the single-cycle special-case path
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        in_valid,
    input  logic        flush,
    output logic        is_muldiv,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [4:0] cnt;
    logic [63:0] acc, acc_nx, prod;
    logic [31:0] opnd, spec_val, in_spec_val, in_a_mag, in_b_mag, q_f, r_f, fin;
    logic [2:0] f3, in_f3;
    logic neg_q, neg_r, spec, in_sa, in_sb, div0, ovf, in_spec, in_fast, accept;
    logic [32:0] sum;
    logic [33:0] diff;
    logic unused;
    assign unused = ^{instruction[24:15], instruction[11:7], diff[32]};
    assign in_f3 = instruction[14:12];
    assign is_muldiv = instruction[6:0] == OPC_ARI_RTYPE && instruction[31:25] == 7'b0000001;
    assign in_sa = op_a[31] & (in_f3[2] ? ~in_f3[0] : ^in_f3[1:0]);
    assign in_sb = op_b[31] & (in_f3[2] ? ~in_f3[0] : in_f3[1:0] == 2'b01);
    assign in_a_mag = in_sa ? -op_a : op_a;
    assign in_b_mag = in_sb ? -op_b : op_b;
    assign div0 = in_f3[2] & op_b == 32'd0;
    assign ovf = in_f3[2] & ~in_f3[0] & op_a == 32'h8000_0000 & op_b == 32'hFFFF_FFFF;
    assign in_spec = div0 | ovf;
    assign in_spec_val = div0 ? (in_f3[1] ? op_a : 32'hFFFF_FFFF)
                       : ovf ? (in_f3[1] ? 32'd0 : 32'h8000_0000) : 32'd0;
`ifdef MULDIV_FASTPATH_EN
    assign in_fast = in_spec | (~in_f3[2] & (op_a == 32'd0 | op_b == 32'd0));
`else
    assign in_fast = 1'b0;
`endif
    assign accept = state == IDLE & in_valid & is_muldiv & ~flush;
    assign busy = state != IDLE;
    assign done = state == DONE & ~flush;
    // one shift-add or restoring-divide step, plus sign fix-up of the final step
    always_comb begin
        sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        diff = {1'b0, acc[63:31]} - {2'b00, opnd};
        acc_nx = f3[2] ? (diff[33] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1})
                       : {sum, acc[31:1]};
        prod = neg_q ? -acc_nx : acc_nx;
        q_f = neg_q ? -acc_nx[31:0] : acc_nx[31:0];
        r_f = neg_r ? -acc_nx[63:32] : acc_nx[63:32];
        fin = spec ? spec_val
            : f3[2] ? (f3[1] ? r_f : q_f)
            : (f3[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // next state: IDLE -> RUN (or DONE on fast path) -> DONE -> IDLE, flush aborts
    always_comb begin
        state_nx = state == IDLE ? (accept ? (in_fast ? DONE : RUN) : IDLE)
                 : state == RUN ? (flush ? IDLE : (cnt == 5'd31 ? DONE : RUN))
                 : IDLE;
    end
    // operand latch at accept, iteration while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 5'd0;
            acc <= 64'd0;
            opnd <= 32'd0;
            f3 <= 3'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            spec <= 1'b0;
            spec_val <= 32'd0;
        end else if (accept) begin
            cnt <= 5'd0;
            acc <= {32'd0, in_f3[2] ? in_a_mag : in_b_mag};
            opnd <= in_f3[2] ? in_b_mag : in_a_mag;
            f3 <= in_f3;
            neg_q <= in_sa ^ in_sb;
            neg_r <= in_sa;
            spec <= in_spec;
            spec_val <= in_spec_val;
        end else if (state == RUN) begin
            cnt <= cnt + 5'd1;
            acc <= acc_nx;
        end
    end
    // result only changes when entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) result <= 32'd0;
        else if (accept & in_fast) result <= in_spec_val;
        else if (state == RUN & ~flush & cnt == 5'd31) result <= fin;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector bench for muldiv_unit
module tb_muldiv_unit;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] instruction = 32'd0, op_a = 32'd0, op_b = 32'd0;
    logic in_valid = 1'b0, flush = 1'b0;
    logic is_muldiv, busy, done;
    logic [31:0] result;
    int errs = 0, checks = 0;
`ifdef MULDIV_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    typedef struct {
        logic [2:0] f3;
        logic [31:0] a, b, exp;
        bit sp;
        string nm;
    } vec_t;
    vec_t v[$];

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .op_a(op_a), .op_b(op_b),
        .in_valid(in_valid), .flush(flush), .is_muldiv(is_muldiv), .busy(busy),
        .done(done), .result(result)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    // starts at a negedge with the unit idle, ends at the negedge after done
    task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit sp, input int poke);
        int lat;
        lat = 99;
        instruction = ins(f3, 7'b0000001, 7'b0110011);
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        instruction = ins(3'($urandom_range(7)), 7'b0000001, 7'b0110011);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) chk({nm, " busy"}, 32'(busy), 32'd1);
            if (done) begin
                lat = k;
                break;
            end
            in_valid = (k == poke);
        end
        in_valid = 1'b0;
        chk({nm, " latency"}, 32'(lat), (FAST && sp) ? 32'd0 : 32'd32);
        chk({nm, " result"}, result, exp);
        @(negedge clk);
        chk({nm, " done_low"}, 32'(done), 32'd0);
        chk({nm, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        bit saw;
        v.push_back('{3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "MUL"});
        v.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "MULH"});
        v.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "MULHU"});
        v.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "MULHSU"});
        v.push_back('{3'b001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, "MULH_neg"});
        v.push_back('{3'b000, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, "MUL_wrap"});
        v.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "DIV"});
        v.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "REM"});
        v.push_back('{3'b101, 32'd100, 32'd7, 32'd14, 1'b0, "DIVU"});
        v.push_back('{3'b111, 32'd100, 32'd7, 32'd2, 1'b0, "REMU"});
        v.push_back('{3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 1'b0, "DIV_neg"});
        v.push_back('{3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 1'b0, "REM_neg"});
        v.push_back('{3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "DIV_by0"});
        v.push_back('{3'b110, 32'd5, 32'd0, 32'd5, 1'b1, "REM_by0"});
        v.push_back('{3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1, "DIV_neg_by0"});
        v.push_back('{3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "DIVU_by0"});
        v.push_back('{3'b111, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 1'b1, "REMU_by0"});
        v.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "DIV_ovf"});
        v.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, "REM_ovf"});
        v.push_back('{3'b000, 32'd0, 32'h0001_2345, 32'd0, 1'b1, "MUL_zero_a"});
        v.push_back('{3'b001, 32'd5, 32'd0, 32'd0, 1'b1, "MULH_zero_b"});

        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        instruction = ins(3'b000, 7'b0000000, 7'b0110011);
        #1 chk("decode ADD", 32'(is_muldiv), 32'd0);
        instruction = ins(3'b000, 7'b0000001, 7'b0010011);
        #1 chk("decode OPIMM", 32'(is_muldiv), 32'd0);
        instruction = ins(3'b110, 7'b0000001, 7'b0110011);
        #1 chk("decode REM", 32'(is_muldiv), 32'd1);
        @(negedge clk);

        foreach (v[i]) do_op(v[i].nm, v[i].f3, v[i].a, v[i].b, v[i].exp, v[i].sp, -1);

        do_op("MUL_poke", 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 5);

        instruction = ins(3'b000, 7'b0000001, 7'b0110011);
        op_a = 32'd9;
        op_b = 32'd9;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        chk("idle flush blocks", 32'(busy), 32'd0);

        instruction = ins(3'b101, 7'b0000001, 7'b0110011);
        op_a = 32'd100;
        op_b = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        saw = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            saw |= done;
            if (k == 10) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        saw |= done;
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush no done", 32'(saw), 32'd0);
        chk("flush result kept", result, 32'd15);
        do_op("REMU_after_flush", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, -1);

        instruction = ins(3'b000, 7'b0000001, 7'b0110011);
        op_a = 32'hFFFF;
        op_b = 32'hFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k <= 20; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun reset busy", 32'(busy), 32'd0);
        chk("midrun reset done", 32'(done), 32'd0);
        chk("midrun reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("MUL_after_reset", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
